// File: rtl/remote_comm.sv
// remote_comm: 16-bit command transmitter (two 8N1 UART frames, high byte
// first) plus an independent 8N1 response receiver, full duplex.
// Optional build macro RX_FRAME_CHECK_EN: when defined, a received byte whose
// stop bit samples low is discarded instead of being delivered.
module remote_comm #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BAUD_DIV / 2) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND_HI = 2'd1, SEND_LO = 2'd2} cmd_state_e;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_e;

  // ---------------- command FSM and byte transmitter ----------------
  cmd_state_e  state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_frame_q, tx_frame_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_baud_q, tx_baud_d;
  logic        tx_start_s;
  logic [7:0]  tx_byte_s;
  logic        tx_last_s;

  // Next-state logic for the command sequencer and the shared bit shifter.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cmd_snt_d  = cmd_snt_q;
    tx_start_s = 1'b0;
    tx_byte_s  = 8'h00;
    tx_last_s  = tx_busy_q && (tx_baud_q == BAUD_LAST) && (tx_bit_q == 4'd9);

    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          hold_d     = cmd;
          cmd_snt_d  = 1'b0;
          tx_start_s = 1'b1;
          tx_byte_s  = cmd[15:8];
          state_d    = SEND_HI;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_HI: begin
        // Low byte is chained directly behind the high byte's stop bit.
        if (tx_last_s) begin
          tx_start_s = 1'b1;
          tx_byte_s  = hold_q[7:0];
          state_d    = SEND_LO;
        end else begin
          state_d = SEND_HI;
        end
      end
      SEND_LO: begin
        if (tx_last_s) begin
          cmd_snt_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = SEND_LO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_frame_d = tx_frame_q;
    tx_bit_d   = tx_bit_q;
    tx_baud_d  = tx_baud_q;
    if (tx_start_s) begin
      // Frame is {stop, data[7:0], start}; bit 0 goes on the line first.
      tx_frame_d = {1'b1, tx_byte_s, 1'b0};
      tx_d       = 1'b0;
      tx_busy_d  = 1'b1;
      tx_bit_d   = 4'd0;
      tx_baud_d  = 16'd0;
    end else if (tx_busy_q) begin
      if (tx_baud_q == BAUD_LAST) begin
        tx_baud_d = 16'd0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_d      = 1'b1;
          tx_bit_d  = 4'd0;
        end else begin
          tx_frame_d = {1'b1, tx_frame_q[9:1]};
          tx_d       = tx_frame_q[1];
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_baud_d = tx_baud_q + 16'd1;
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  // Command FSM and transmitter registers; reset forces the line idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= 16'h0000;
      cmd_snt_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_frame_q <= 10'h3FF;
      tx_bit_q   <= 4'd0;
      tx_baud_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cmd_snt_q  <= cmd_snt_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_frame_q <= tx_frame_d;
      tx_bit_q   <= tx_bit_d;
      tx_baud_q  <= tx_baud_d;
    end
  end

  // ---------------- receiver ----------------
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_rdy_q, resp_rdy_d;

  // Two-flop synchronizer for the asynchronous RX pin plus an edge-detect tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver sequencing: start validation at half-bit, then mid-bit sampling.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    resp_d     = resp_q;
    resp_rdy_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_baud_d  = 16'd0;
          rx_bit_d   = 4'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d = 16'd0;
          // A line already back high at start-bit centre was a glitch.
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = 16'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 4'd7) begin
            rx_bit_d   = 4'd0;
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = 16'd0;
          rx_state_d = RX_IDLE;
`ifdef RX_FRAME_CHECK_EN
          if (rx_sync_q) begin
            resp_d     = rx_shift_q;
            resp_rdy_d = 1'b1;
          end else begin
            resp_d     = resp_q;
            resp_rdy_d = 1'b0;
          end
`else
          resp_d     = rx_shift_q;
          resp_rdy_d = 1'b1;
`endif
        end else begin
          rx_baud_d = rx_baud_q + 16'd1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Receiver registers, including the registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= 16'd0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign TX       = tx_q;
  assign cmd_snt  = cmd_snt_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm at BAUD_DIV=16: scoreboard queues hold
// expected TX bytes and RX responses; monitors pop and compare.
module tb_remote_comm;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rx_start_cyc = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // TX line decoder: samples each bit at its centre on the falling clock edge.
  always begin
    logic [7:0] b;
    logic bad;
    logic st;
    @(negedge clk);
    if (!rst && TX === 1'b0) begin
      bad = 1'b0;
      repeat (BD / 2) begin @(negedge clk); if (rst) bad = 1'b1; end
      st = TX;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) begin @(negedge clk); if (rst) bad = 1'b1; end
        b[i] = TX;
      end
      repeat (BD) begin @(negedge clk); if (rst) bad = 1'b1; end
      if (!bad) begin
        check_eq("tx_start_bit", {31'd0, st}, 32'd0);
        check_eq("tx_stop_bit", {31'd0, TX}, 32'd1);
        if (tx_exp.size() == 0) check_eq("tx_extra_frame", {24'd0, b}, 32'hFFFF_FFFF);
        else check_eq("tx_byte", {24'd0, b}, {24'd0, tx_exp.pop_front()});
      end
    end
  end

  // Response monitor: value, timing relative to frame start, one-cycle pulse.
  always begin
    int lat;
    @(negedge clk);
    if (!rst && resp_rdy === 1'b1) begin
      lat = cyc - rx_start_cyc;
      if (rx_exp.size() == 0) begin
        check_eq("rx_extra_pulse", {24'd0, resp}, 32'hFFFF_FFFF);
      end else begin
        rx_last = rx_exp.pop_front();
        check_eq("rx_resp", {24'd0, resp}, {24'd0, rx_last});
        check_eq("rx_latency_ok", {31'd0, (lat >= 153 && lat <= 157)}, 32'd1);
      end
      @(negedge clk);
      check_eq("rx_pulse_width", {31'd0, resp_rdy}, 32'd0);
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    rx_start_cyc = cyc;
    RX = 1'b0;
    repeat (BD) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    RX = stop;
    repeat (BD) @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (BD) @(posedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] c, input bit inject);
    int lat;
    @(posedge clk); #1;
    cmd = c;
    snd_cmd = 1'b1;
    tx_exp.push_back(c[15:8]);
    tx_exp.push_back(c[7:0]);
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    cmd = 16'h0000;
    lat = 0;
    check_eq("cmd_snt_cleared", {31'd0, cmd_snt}, 32'd0);
    while (cmd_snt !== 1'b1 && lat < 400) begin
      if (inject && lat == 50) begin
        cmd = 16'h2000;
        snd_cmd = 1'b1;
      end else begin
        snd_cmd = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    snd_cmd = 1'b0;
    check_eq("cmd_latency_ok", {31'd0, (lat >= 20 * BD && lat <= 20 * BD + 3)}, 32'd1);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_tx", {31'd0, TX}, 32'd1);
    check_eq("rst_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    check_eq("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check_eq("rst_resp", {24'd0, resp}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Plain command, then a command with an ignored mid-flight request.
    send_cmd(16'h4BF1, 1'b0);
    repeat (20) @(posedge clk);
    send_cmd(16'hC35A, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    check_eq("cmd_snt_held", {31'd0, cmd_snt}, 32'd1);

    // Valid response byte.
    rx_exp.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    repeat (10) @(posedge clk);

    // False start: 4-clock low glitch.
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (3 * BD) @(posedge clk);
    #1;
    check_eq("false_start_resp_hold", {24'd0, resp}, {24'd0, rx_last});

    // Framing error: stop bit low.
`ifndef RX_FRAME_CHECK_EN
    rx_exp.push_back(8'h3C);
`endif
    send_rx(8'h3C, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("frame_err_resp", {24'd0, resp}, {24'd0, rx_last});

    // Full duplex: command and response concurrently.
    rx_exp.push_back(8'h7E);
    fork
      send_cmd(16'h1234, 1'b0);
      send_rx(8'h7E, 1'b1);
    join
    repeat (20) @(posedge clk);

    // Reset in the middle of a frame.
    @(posedge clk); #1;
    cmd = 16'h4002;
    snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_tx", {31'd0, TX}, 32'd1);
    check_eq("midrst_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    check_eq("midrst_resp", {24'd0, resp}, 32'd0);
    rst = 1'b0;
    rx_last = 8'h00;
    repeat (200) @(posedge clk);
    send_cmd(16'h4002, 1'b0);
    repeat (200) @(posedge clk);

    check_eq("tx_queue_empty", tx_exp.size(), 32'd0);
    check_eq("rx_queue_empty", rx_exp.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
